// File: rtl/pwm_write_arbiter.sv
// pwm_write_arbiter: owns the shared PWM register write bus (_Write/AddressBus/WriteBus).
// Host register writes are forwarded one cycle later and always take priority.
// A per-channel ramp engine moves each duty byte toward a target. Its writes are
// interleaved round-robin into cycles with no host write.
// Optional feature: define PWM_RAMP_IRQ_EN to add the active-low _IRQ ramp-completion
// output. It is cleared by a host write to RampBase + 4*NumOfPWMOutputs.

// One ramp lane: config registers, duty mirror, interval counter and pending flag.
module pwm_ramp_channel (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       grant,
    input  logic       wr_target,
    input  logic       wr_step,
    input  logic       wr_interval,
    input  logic       wr_duty,
    input  logic [7:0] wdata,
    output logic       pend,
    output logic       active,
    output logic [7:0] nxt_cur
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic       done
`endif
);
    logic [7:0] cur;
    logic [7:0] target;
    logic [7:0] step;
    logic [7:0] interval;
    logic [7:0] cnt;
    logic       tick_pend;
    logic       reach;

    // Next duty value: one STEP toward TARGET, clamped at TARGET. STEP=0 jumps.
    // The differences are only taken in the direction that cannot underflow.
    // An add is only taken while it stays below TARGET, so it never wraps.
    always_comb begin
        nxt_cur = target;
        if (step != 8'd0) begin
            if (cur < target) begin
                if ((target - cur) > step) nxt_cur = cur + step;
            end else if (cur > target) begin
                if ((cur - target) > step) nxt_cur = cur - step;
            end
        end
    end

    assign reach     = (nxt_cur == target);
    assign tick_pend = tick & active & (cnt == 8'd0);

`ifdef PWM_RAMP_IRQ_EN
    // Completion only: a duty-write cancel never passes through a grant.
    assign done = grant & reach;
`endif

    // Host-programmed ramp configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target   <= 8'd0;
            step     <= 8'd1;
            interval <= 8'd0;
        end else begin
            if (wr_target)   target   <= wdata;
            if (wr_step)     step     <= wdata;
            if (wr_interval) interval <= wdata;
        end
    end

    // Ramp state. Host writes override ticks and grants.
    // A tick that expires the counter re-arms PEND even while the previous
    // period's request is being granted, unless that grant finishes the ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= 8'd0;
            cnt    <= 8'd0;
            pend   <= 1'b0;
            active <= 1'b0;
        end else if (wr_duty) begin
            cur    <= wdata;
            active <= 1'b0;
            pend   <= 1'b0;
        end else if (wr_target) begin
            active <= 1'b1;
            pend   <= 1'b0;
            cnt    <= interval;
        end else begin
            if (tick && active) cnt <= (cnt == 8'd0) ? interval : cnt - 8'd1;
            if (grant) begin
                cur <= nxt_cur;
                if (reach) begin
                    active <= 1'b0;
                    pend   <= 1'b0;
                end else begin
                    pend <= tick_pend;
                end
            end else if (tick_pend) begin
                pend <= 1'b1;
            end
        end
    end
endmodule

module pwm_write_arbiter #(
    parameter int NumOfPWMOutputs = 4,
    parameter int RegStride       = 6,
    parameter int DutyOffset      = 0,
    parameter int RampBase        = 24,
    parameter int TickDiv         = 256
) (
    input  logic                       CLK,
    input  logic                       _RST,
    input  logic                       HostWrite,
    input  logic [7:0]                 HostAddress,
    input  logic [7:0]                 HostData,
    output logic                       _Write,
    output logic [7:0]                 AddressBus,
    output logic [7:0]                 WriteBus,
    output logic [NumOfPWMOutputs-1:0] RampActive
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic                       _IRQ
`endif
);
    localparam int             N         = NumOfPWMOutputs;
    localparam int             CW        = (N > 1) ? $clog2(N) : 1;
    localparam int             PW        = $clog2(TickDiv);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(TickDiv - 1);
    localparam logic [7:0]     RAMP_BASE = 8'(RampBase);
    localparam logic [N-1:0]   ONE       = N'(1);

    logic [PW-1:0]         pre;
    logic                  tick;
    logic                  is_cfg;
    logic                  fwd;
    logic [7:0]            cfg_off;
    logic [CW-1:0]         ptr;
    logic [N-1:0]          pend;
    logic [N-1:0]          after_ptr;
    logic [N-1:0]          req;
    logic [N-1:0]          hi_req;
    logic [N-1:0]          lo_req;
    logic [N-1:0]          hi_oh;
    logic [N-1:0]          lo_oh;
    logic [N-1:0]          gnt;
    logic [N-1:0][7:0]     nxt_cur;
    logic [7:0][N-1:0]     data_col;
    logic [7:0][N-1:0]     addr_col;
    logic [CW-1:0][N-1:0]  idx_col;
    logic [7:0]            gnt_data;
    logic [7:0]            gnt_addr;
    logic [CW-1:0]         gnt_idx;
`ifdef PWM_RAMP_IRQ_EN
    localparam logic [7:0] IRQ_CLR_ADDR = 8'(RampBase + 4 * N);
    logic [N-1:0]          done;
`endif

    assign tick = (pre == PRE_LAST);

    // Free-running ramp prescaler. It pulses tick once every TickDiv cycles.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) pre <= '0;
        else       pre <= tick ? '0 : pre + PW'(1);
    end

    // Host address decode. Config space starts at RampBase and is never forwarded.
    assign is_cfg  = (HostAddress >= RAMP_BASE);
    assign cfg_off = HostAddress - RAMP_BASE;
    assign fwd     = HostWrite & ~is_cfg;

    genvar c, b;
    for (c = 0; c < N; c++) begin : g_ch
        localparam logic [7:0]    DUTY_ADDR = 8'(c * RegStride + DutyOffset);
        localparam logic [CW-1:0] IDX       = CW'(c);
        logic sel;

        assign sel = HostWrite & is_cfg & (cfg_off[7:2] == 6'(c));

        pwm_ramp_channel u_ch (
            .clk         (CLK),
            .rst_n       (_RST),
            .tick        (tick),
            .grant       (gnt[c]),
            .wr_target   (sel & (cfg_off[1:0] == 2'd0)),
            .wr_step     (sel & (cfg_off[1:0] == 2'd1)),
            .wr_interval (sel & (cfg_off[1:0] == 2'd2)),
            .wr_duty     (fwd & (HostAddress == DUTY_ADDR)),
            .wdata       (HostData),
            .pend        (pend[c]),
            .active      (RampActive[c]),
            .nxt_cur     (nxt_cur[c])
`ifdef PWM_RAMP_IRQ_EN
            ,
            .done        (done[c])
`endif
        );

        assign after_ptr[c] = (IDX > ptr);

        // Transposed copies so the granted lane can be selected by AND-OR reduction.
        for (b = 0; b < 8; b++) begin : g_bit
            assign data_col[b][c] = nxt_cur[c][b];
            assign addr_col[b][c] = DUTY_ADDR[b];
        end
        for (b = 0; b < CW; b++) begin : g_idx
            assign idx_col[b][c] = IDX[b];
        end
    end

    // Round-robin: the lowest pending lane above the last grant, else the lowest overall.
    // Any host write blocks all grants that cycle, so the requests stay pending.
    assign req    = HostWrite ? '0 : pend;
    assign hi_req = req & after_ptr;
    assign lo_req = req & ~after_ptr;
    assign hi_oh  = hi_req & (~hi_req + ONE);
    assign lo_oh  = lo_req & (~lo_req + ONE);
    assign gnt    = (hi_req != '0) ? hi_oh : lo_oh;

    for (b = 0; b < 8; b++) begin : g_mux
        assign gnt_data[b] = |(gnt & data_col[b]);
        assign gnt_addr[b] = |(gnt & addr_col[b]);
    end
    for (b = 0; b < CW; b++) begin : g_imux
        assign gnt_idx[b] = |(gnt & idx_col[b]);
    end

    // Registered write bus. A forwarded host write wins, then a ramp grant.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            _Write     <= 1'b1;
            AddressBus <= 8'd0;
            WriteBus   <= 8'd0;
            ptr        <= '0;
        end else begin
            _Write <= 1'b1;
            if (fwd) begin
                _Write     <= 1'b0;
                AddressBus <= HostAddress;
                WriteBus   <= HostData;
            end else if (gnt != '0) begin
                _Write     <= 1'b0;
                AddressBus <= gnt_addr;
                WriteBus   <= gnt_data;
                ptr        <= gnt_idx;
            end
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    // Completion interrupt. A completion beats a clear in the same cycle.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST)                                           _IRQ <= 1'b1;
        else if (done != '0)                                 _IRQ <= 1'b0;
        else if (HostWrite && (HostAddress == IRQ_CLR_ADDR)) _IRQ <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_pwm_write_arbiter.sv
// Scoreboard bench for pwm_write_arbiter: the stimulus pushes the expected bus writes
// (address, data, and the required spacing from the previous bus write) into a queue.
// A negedge monitor pops and compares every write the DUT puts on the bus.
module tb_pwm_write_arbiter;
    localparam int TD = 16;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         gap;   // 0: any spacing; otherwise the exact cycles since previous write
    } exp_t;

    logic       CLK;
    logic       _RST;
    logic       HostWrite;
    logic [7:0] HostAddress;
    logic [7:0] HostData;
    logic       _Write;
    logic [7:0] AddressBus;
    logic [7:0] WriteBus;
    logic [3:0] RampActive;
`ifdef PWM_RAMP_IRQ_EN
    logic       _IRQ;
`endif

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_wr = 0;

    pwm_write_arbiter #(
        .NumOfPWMOutputs (4),
        .RegStride       (6),
        .DutyOffset      (0),
        .RampBase        (24),
        .TickDiv         (TD)
    ) dut (
        .CLK         (CLK),
        ._RST        (_RST),
        .HostWrite   (HostWrite),
        .HostAddress (HostAddress),
        .HostData    (HostData),
        ._Write      (_Write),
        .AddressBus  (AddressBus),
        .WriteBus    (WriteBus),
        .RampActive  (RampActive)
`ifdef PWM_RAMP_IRQ_EN
        ,
        ._IRQ        (_IRQ)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Monitor: every bus write must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (_Write === 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%0d data=%02h", AddressBus, WriteBus);
                end else begin
                    e = exp_q.pop_front();
                    if (AddressBus !== e.addr || WriteBus !== e.data ||
                        (e.gap != 0 && (cyc - last_wr) != e.gap)) begin
                        bad++;
                        $display("FAIL bus_write got addr=%0d data=%02h gap=%0d want addr=%0d data=%02h gap=%0d",
                                 AddressBus, WriteBus, cyc - last_wr, e.addr, e.data, e.gap);
                    end
                end
                last_wr = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d, input int g);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 with the strobe sampled.
    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        HostWrite   = 1'b1;
        HostAddress = a;
        HostData    = d;
        @(posedge CLK);
        #1;
        HostWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout pending=%0d", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        _RST        = 1'b0;
        HostWrite   = 1'b0;
        HostAddress = 8'd0;
        HostData    = 8'd0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_write", _Write, 1);
        check("rst_addr", AddressBus, 0);
        check("rst_data", WriteBus, 0);
        check("rst_active", RampActive, 0);
        @(posedge CLK);
        #1;
        _RST = 1'b1;
        idle(2);

        // Forwarding, and a config write that must stay off the bus (STEP[0]=0x40).
        expect_wr(8'd7, 8'h5A, 0);
        host_wr(8'd7, 8'h5A);
        check("fwd_strobe", _Write, 0);
        idle(1);
        check("fwd_one_cycle", _Write, 1);
        host_wr(8'd25, 8'h40);
        check("cfg_not_fwd", _Write, 1);
        idle(2);

        // Upward ramp on channel 0: every second tick, clamped at 0xB0.
        host_wr(8'd26, 8'd1);
        expect_wr(8'd0, 8'h40, 0);
        expect_wr(8'd0, 8'h80, 2 * TD);
        expect_wr(8'd0, 8'hB0, 2 * TD);
        host_wr(8'd24, 8'hB0);
        check("ramp0_active", RampActive, 4'b0001);
        wait_drain("ramp_up", 10 * TD);
        idle(1);
        check("ramp0_done", RampActive, 0);

        // Downward ramp, clamped at 0x10 without wrapping.
        host_wr(8'd25, 8'h60);
        expect_wr(8'd0, 8'h50, 0);
        expect_wr(8'd0, 8'h10, 2 * TD);
        host_wr(8'd24, 8'h10);
        wait_drain("ramp_down", 8 * TD);
        idle(1);
        check("ramp_down_done", RampActive, 0);

        // TARGET equal to CUR on channel 3: one write of CUR, then idle.
        expect_wr(8'd18, 8'h00, 0);
        host_wr(8'd36, 8'h00);
        wait_drain("equal_target", 4 * TD);
        idle(1);
        check("equal_target_idle", RampActive, 0);

        // Arbitration: all four channels jump (STEP=0) while a long host burst holds the bus.
        host_wr(8'd25, 8'd0);
        host_wr(8'd26, 8'd0);
        host_wr(8'd29, 8'd0);
        host_wr(8'd33, 8'd0);
        host_wr(8'd37, 8'd0);
        host_wr(8'd24, 8'h11);
        host_wr(8'd28, 8'h22);
        host_wr(8'd32, 8'h33);
        host_wr(8'd36, 8'h44);
        check("arb_all_active", RampActive, 4'hF);
        for (int i = 0; i < TD + 3; i++) begin
            expect_wr(8'(1 + i % 5), 8'(i), (i == 0) ? 0 : 1);
            host_wr(8'(1 + i % 5), 8'(i));
        end
        expect_wr(8'd0, 8'h11, 1);
        expect_wr(8'd6, 8'h22, 1);
        expect_wr(8'd12, 8'h33, 1);
        expect_wr(8'd18, 8'h44, 1);
        wait_drain("arbitration", 4 * TD);
        idle(1);
        check("arb_done", RampActive, 0);

        // Cancel a ramp on channel 2 with a duty write.
        host_wr(8'd33, 8'h10);
        expect_wr(8'd12, 8'h43, 0);
        host_wr(8'd32, 8'hF3);
        wait_drain("cancel_first", 4 * TD);
        expect_wr(8'd12, 8'h33, 0);
        host_wr(8'd12, 8'h33);
        check("cancel_active", RampActive, 0);
        idle(3 * TD);
        wait_drain("cancel_fwd", 4);

        // Reset in the middle of a ramp on channel 1.
        host_wr(8'd29, 8'h01);
        expect_wr(8'd6, 8'h23, 0);
        host_wr(8'd28, 8'hFF);
        check("pre_reset_active", RampActive, 4'b0010);
        wait_drain("pre_reset", 4 * TD);
        idle(TD / 2);
        _RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_write", _Write, 1);
        check("mid_rst_addr", AddressBus, 0);
        check("mid_rst_data", WriteBus, 0);
        check("mid_rst_active", RampActive, 0);
        @(posedge CLK);
        #1;
        _RST = 1'b1;
        idle(3 * TD);
        check("post_rst_active", RampActive, 0);
`ifdef PWM_RAMP_IRQ_EN
        check("irq_reset", _IRQ, 1);
`endif

        // Post-reset ramp shows CUR=0 and STEP=1 defaults; completion raises _IRQ.
        expect_wr(8'd6, 8'h01, 0);
        expect_wr(8'd6, 8'h02, TD);
        host_wr(8'd28, 8'h02);
        wait_drain("post_rst_ramp", 4 * TD);
        idle(1);
        check("post_rst_done", RampActive, 0);
`ifdef PWM_RAMP_IRQ_EN
        check("irq_set", _IRQ, 0);
`endif
        host_wr(8'd40, 8'h00);
`ifdef PWM_RAMP_IRQ_EN
        check("irq_clear", _IRQ, 1);
`endif
        idle(4);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
